// File: rtl/mo_line_scheduler.sv
// Motion-object line scheduler: ping-pong counter clear/load strobes plus one object-table walk per line.
// Latency: all outputs registered; sequencing advances on ce5 ticks, fetch ack latched on any clk.
// Backpressure: obj_req held until obj_ack; a scan still running at the line wrap is aborted and flagged.
module mo_line_scheduler #(
    parameter int H_TOTAL = 320,
    parameter int N_OBJ   = 16,
    parameter int OBJ_W   = 8,
    localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
    localparam int DW = $clog2(OBJ_W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce5,
    input  logic          vblank,
    input  logic          obj_ack,
    input  logic          obj_hit,
    output logic          obj_req,
    output logic [IW-1:0] obj_idx,
    output logic          ld1_n,
    output logic          ld2_n,
    output logic          cl1_n,
    output logic          cl2_n,
    output logic          bank,
    output logic          wr_en,
    output logic [8:0]    hpos,
    output logic          overflow
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_DRAW, S_NEXT} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [8:0]    hpos_d;
    logic          req_d, got_q, got_d, hit_q, hit_d, wr_d;
    logic          ld1_d, ld2_d, cl1_d, cl2_d, bank_d, ovf_d;
    logic          start_q, start_d;
    logic          wrap;

    assign wrap = ce5 && (hpos == 9'(H_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            obj_idx  <= '0;
            cnt_q    <= '0;
            hpos     <= '0;
            obj_req  <= 1'b0;
            got_q    <= 1'b0;
            hit_q    <= 1'b0;
            wr_en    <= 1'b0;
            ld1_n    <= 1'b1;
            ld2_n    <= 1'b1;
            cl1_n    <= 1'b1;
            cl2_n    <= 1'b1;
            bank     <= 1'b0;
            overflow <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            obj_idx  <= idx_d;
            cnt_q    <= cnt_d;
            hpos     <= hpos_d;
            obj_req  <= req_d;
            got_q    <= got_d;
            hit_q    <= hit_d;
            wr_en    <= wr_d;
            ld1_n    <= ld1_d;
            ld2_n    <= ld2_d;
            cl1_n    <= cl1_d;
            cl2_n    <= cl2_d;
            bank     <= bank_d;
            overflow <= ovf_d;
            start_q  <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = obj_idx;
        cnt_d   = cnt_q;
        hpos_d  = hpos;
        req_d   = obj_req;
        got_d   = got_q;
        hit_d   = hit_q;
        wr_d    = wr_en;
        ld1_d   = ld1_n;
        ld2_d   = ld2_n;
        cl1_d   = cl1_n;
        cl2_d   = cl2_n;
        bank_d  = bank;
        ovf_d   = overflow;
        start_d = start_q;

        // The handshake is the only thing that moves between ce5 ticks.
        if (obj_req && obj_ack) begin
            req_d = 1'b0;
            got_d = 1'b1;
            hit_d = obj_hit;
        end

        if (ce5) begin
            hpos_d  = wrap ? 9'd0 : hpos + 9'd1;
            start_d = wrap;
            ld1_d   = 1'b1;
            ld2_d   = 1'b1;
            cl1_d   = 1'b1;
            cl2_d   = 1'b1;
            if (wrap) begin
                // New display counter is counter 1 when the toggled bank is 0.
                bank_d  = ~bank;
                cl1_d   = ~bank;
                cl2_d   = bank;
                ovf_d   = (state_q != S_IDLE);
                state_d = S_IDLE;
                req_d   = 1'b0;
                got_d   = 1'b0;
                wr_d    = 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_q && !vblank) begin
                            state_d = S_FETCH;
                            idx_d   = '0;
                            req_d   = 1'b1;
                            got_d   = 1'b0;
                        end
                    end
                    S_FETCH: begin
                        if (got_q) begin
                            got_d = 1'b0;
                            if (hit_q) begin
                                state_d = S_LOAD;
                                ld1_d   = ~bank;
                                ld2_d   = bank;
                            end else begin
                                state_d = S_NEXT;
                            end
                        end
                    end
                    S_LOAD: begin
                        state_d = S_DRAW;
                        wr_d    = 1'b1;
                        cnt_d   = '0;
                    end
                    S_DRAW: begin
                        if (cnt_q == DW'(OBJ_W - 1)) begin
                            state_d = S_NEXT;
                            wr_d    = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    S_NEXT: begin
                        if (obj_idx == IW'(N_OBJ - 1)) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_FETCH;
                            idx_d   = obj_idx + 1'b1;
                            req_d   = 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mo_line_scheduler.sv
// Bench for mo_line_scheduler: line-level timeline model, directed line table, random lines, reset mid-draw.
module tb_mo_line_scheduler;
    localparam int H = 320;
    localparam int N = 16;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset, ce5, vblank, obj_ack, obj_hit;
    logic       obj_req, ld1_n, ld2_n, cl1_n, cl2_n, bank, wr_en, overflow;
    logic [3:0] obj_idx;
    logic [8:0] hpos;

    always #5 clk = ~clk;

    mo_line_scheduler #(.H_TOTAL(H), .N_OBJ(N), .OBJ_W(W)) dut (
        .clk(clk), .reset(reset), .ce5(ce5), .vblank(vblank),
        .obj_ack(obj_ack), .obj_hit(obj_hit), .obj_req(obj_req), .obj_idx(obj_idx),
        .ld1_n(ld1_n), .ld2_n(ld2_n), .cl1_n(cl1_n), .cl2_n(cl2_n),
        .bank(bank), .wr_en(wr_en), .hpos(hpos), .overflow(overflow)
    );

    typedef struct {
        bit          vb;
        logic [15:0] mask;
        int          dly;
        int          ld_first, ld_cnt, wr_first, wr_cnt, last_req;
        bit          ovf;
    } row_t;
    row_t rows[7];

    int n_tests = 0;
    int n_fail  = 0;

    // Expected per-period activity of the current line.
    bit m_req[H];
    int m_idx[H];
    bit m_ld[H];
    bit m_wr[H];
    bit m_ovf;
    bit exp_bank = 1'b0;
    bit prev_ovf = 1'b0;
    int dly[N];
    int ms_ld_first, ms_ld_cnt, ms_ld_wrong, ms_wr_first, ms_wr_cnt, ms_last_req;

    task automatic chk(input string name, input int h, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (hpos %0d): got %0d, expected %0d", name, h, act, exp);
        end
    endtask

    // Slot timeline from the cost rules: fetch lasts delay+1 periods, then
    // a hit spends LOAD + OBJ_W DRAW + NEXT, a miss just NEXT. Scan starts in period 1.
    task automatic build_model(input bit scan, input logic [15:0] mask);
        int t;
        for (int h = 0; h < H; h++) begin
            m_req[h] = 0; m_idx[h] = 0; m_ld[h] = 0; m_wr[h] = 0;
        end
        m_ovf = 0;
        if (scan) begin
            t = 1;
            for (int s = 0; s < N; s++) begin
                for (int p = 0; p <= dly[s]; p++)
                    if (t + p < H) begin m_req[t + p] = 1; m_idx[t + p] = s; end
                t += dly[s] + 1;
                if (mask[s]) begin
                    if (t < H) m_ld[t] = 1;
                    for (int p = 1; p <= W; p++) if (t + p < H) m_wr[t + p] = 1;
                    t += W + 2;
                end else begin
                    t += 1;
                end
            end
            m_ovf = (t >= H);
        end
    endtask

    task automatic run_line(input bit vb, input logic [15:0] mask, input bit from_wrap,
                            input bit scan_ok, input bit spur, input int nper);
        bit scan, do_ack, hit_v, wld, bld;
        int wait_cnt;
        scan = !vb && scan_ok;
        build_model(scan, mask);
        if (from_wrap) exp_bank = ~exp_bank;
        vblank = vb;
        wait_cnt = 0;
        ms_ld_first = -1; ms_ld_cnt = 0; ms_ld_wrong = 0;
        ms_wr_first = -1; ms_wr_cnt = 0; ms_last_req = -1;
        for (int h = 0; h < nper; h++) begin
            chk("hpos", h, 32'(hpos), 32'(h));
            chk("bank", h, 32'(bank), 32'(exp_bank));
            chk("overflow", h, 32'(overflow), 32'(prev_ovf));
            chk("cl1_n", h, 32'(cl1_n), 32'(!(from_wrap && h == 0 && exp_bank == 1'b0)));
            chk("cl2_n", h, 32'(cl2_n), 32'(!(from_wrap && h == 0 && exp_bank == 1'b1)));
            chk("ld1_n", h, 32'(ld1_n), 32'(!(m_ld[h] && exp_bank == 1'b1)));
            chk("ld2_n", h, 32'(ld2_n), 32'(!(m_ld[h] && exp_bank == 1'b0)));
            chk("wr_en", h, 32'(wr_en), 32'(m_wr[h]));
            chk("obj_req", h, 32'(obj_req), 32'(m_req[h]));
            if (m_req[h]) chk("obj_idx", h, 32'(obj_idx), 32'(m_idx[h]));

            wld = exp_bank ? !ld1_n : !ld2_n;
            bld = exp_bank ? !ld2_n : !ld1_n;
            if (wld) begin ms_ld_cnt++; if (ms_ld_first < 0) ms_ld_first = h; end
            if (bld) ms_ld_wrong++;
            if (wr_en) begin ms_wr_cnt++; if (ms_wr_first < 0) ms_wr_first = h; end
            if (obj_req) ms_last_req = h;

            do_ack = 0;
            hit_v  = 0;
            if (obj_req) begin
                if (wait_cnt >= dly[obj_idx]) begin
                    do_ack = 1; hit_v = mask[obj_idx]; wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (spur && $urandom_range(0, 3) == 0) begin
                do_ack = 1; hit_v = 1;
            end
            for (int c = 0; c < 5; c++) begin
                ce5     = (c == 4);
                obj_ack = (c == 1) && do_ack;
                obj_hit = hit_v;
                @(posedge clk); #1;
            end
            ce5 = 0; obj_ack = 0;
        end
        if (nper == H) prev_ovf = m_ovf;
    endtask

    initial begin
        rows[0] = '{0, 16'h0001,  0,  2,  1,  3,   8,  40, 0};
        rows[1] = '{0, 16'h0000,  0, -1,  0, -1,   0,  31, 0};
        rows[2] = '{0, 16'hFFFF,  0,  2, 16,  3, 128, 166, 0};
        rows[3] = '{0, 16'hFFFF, 10, 12, 15, 13, 120, 319, 1};
        rows[4] = '{1, 16'hFFFF,  0, -1,  0, -1,   0,  -1, 0};
        rows[5] = '{0, 16'h8001,  3,  5,  2,  6,  16,  88, 0};
        rows[6] = '{0, 16'h0001,  0,  2,  1,  3,   8,  40, 0};

        reset = 1; ce5 = 0; vblank = 0; obj_ack = 0; obj_hit = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("rst obj_idx", 0, 32'(obj_idx), 0);
        chk("rst strobes", 0, {28'd0, ld1_n, ld2_n, cl1_n, cl2_n}, 32'hF);

        // First line after reset: no scan, no clear pulse.
        for (int s = 0; s < N; s++) dly[s] = 0;
        run_line(0, 16'hFFFF, 0, 0, 1, H);

        for (int r = 0; r < 7; r++) begin
            for (int s = 0; s < N; s++) dly[s] = rows[r].dly;
            run_line(rows[r].vb, rows[r].mask, 1, 1, 0, H);
            chk("row ld_first", r, 32'(ms_ld_first), 32'(rows[r].ld_first));
            chk("row ld_cnt", r, 32'(ms_ld_cnt), 32'(rows[r].ld_cnt));
            chk("row ld_wrong_counter", r, 32'(ms_ld_wrong), 0);
            chk("row wr_first", r, 32'(ms_wr_first), 32'(rows[r].wr_first));
            chk("row wr_cnt", r, 32'(ms_wr_cnt), 32'(rows[r].wr_cnt));
            chk("row last_req", r, 32'(ms_last_req), 32'(rows[r].last_req));
            chk("row ovf_next", r, 32'(overflow), 32'(rows[r].ovf));
        end

        for (int l = 0; l < 10; l++) begin
            bit vb, big;
            logic [15:0] mask;
            vb   = ($urandom_range(0, 7) == 0);
            big  = ($urandom_range(0, 3) == 0);
            mask = 16'($urandom);
            for (int s = 0; s < N; s++) dly[s] = big ? $urandom_range(0, 12) : $urandom_range(0, 2);
            run_line(vb, mask, 1, 1, 1, H);
        end

        // Reset in the middle of the DRAW of slot 0.
        for (int s = 0; s < N; s++) dly[s] = 0;
        run_line(0, 16'h0001, 1, 1, 0, 6);
        chk("pre-reset wr_en", 6, 32'(wr_en), 1);
        reset = 1;
        @(posedge clk); #1;
        chk("mid reset wr_en", 0, 32'(wr_en), 0);
        chk("mid reset obj_req", 0, 32'(obj_req), 0);
        chk("mid reset hpos", 0, 32'(hpos), 0);
        chk("mid reset bank", 0, 32'(bank), 0);
        chk("mid reset overflow", 0, 32'(overflow), 0);
        chk("mid reset strobes", 0, {28'd0, ld1_n, ld2_n, cl1_n, cl2_n}, 32'hF);
        @(posedge clk); #1 reset = 0;
        exp_bank = 0;
        prev_ovf = 0;
        run_line(0, 16'h0001, 0, 0, 1, H);
        run_line(0, 16'h0001, 1, 1, 0, H);
        chk("resume ld_first", 0, 32'(ms_ld_first), 2);
        chk("resume wr_cnt", 0, 32'(ms_wr_cnt), 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
